// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller: one external pipelined 1-bit full adder computes a
// WIDTH-bit sum, LSB first, with each returned carry fed back as the next carry-in.
module serial_add_sequencer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned FA_LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam int unsigned CntW = $clog2(FA_LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [IdxW-1:0]   bit_q, bit_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              fa_a_q, fa_a_d;
  logic              fa_b_q, fa_b_d;
  logic              fa_cin_q, fa_cin_d;

  logic last_bit;
  logic sample;

  assign last_bit = (bit_q == IdxW'(WIDTH - 1));
  assign sample   = (state_q == StWait) && (cnt_q == CntW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      bit_q    <= '0;
      cnt_q    <= '0;
      fa_a_q   <= 1'b0;
      fa_b_q   <= 1'b0;
      fa_cin_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      fa_a_q   <= fa_a_d;
      fa_b_q   <= fa_b_d;
      fa_cin_q <= fa_cin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (sample) state_d = last_bit ? StDone : StIssue;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The fa_* pulse is registered, so it is prepared on the edge that enters StIssue.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    fa_a_d   = 1'b0;
    fa_b_d   = 1'b0;
    fa_cin_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d      = in_a;
          b_d      = in_b;
          carry_d  = in_cin;
          bit_d    = '0;
          fa_a_d   = in_a[0];
          fa_b_d   = in_b[0];
          fa_cin_d = in_cin;
        end
      end
      StIssue: begin
        cnt_d = CntW'(FA_LATENCY);
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (sample) begin
          // Sum bits enter at the MSB; after WIDTH samples bit 0 holds the first.
          sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
          carry_d = fa_cout;
          if (!last_bit) begin
            bit_d    = bit_q + IdxW'(1);
            fa_a_d   = a_q[0];
            fa_b_d   = b_q[0];
            fa_cin_d = fa_cout;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    out_valid = (state_q == StDone);
    out_sum   = sum_q;
    out_cout  = carry_q;
    fa_a      = fa_a_q;
    fa_b      = fa_b_q;
    fa_cin    = fa_cin_q;
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer: clocked full-adder model with 3-cycle latency,
// result scoreboard and per-cycle check of the fa_* pulse pattern.
module tb_serial_add_sequencer;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned LAT     = 3;
  localparam int          P       = LAT + 1;
  localparam int          FirstOv = WIDTH * P + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_cout;

  serial_add_sequencer #(
    .WIDTH      (WIDTH),
    .FA_LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_cin    (fa_cin),
    .fa_sum    (fa_sum),
    .fa_cout   (fa_cout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Full-adder cell model: LAT register stages.
  logic [LAT-1:0] p_sum  = '0;
  logic [LAT-1:0] p_cout = '0;
  int             cyc    = 0;
  int             t0     = 0;
  int             rel_c;
  logic           spur_en = 1'b0;
  logic           spur_now;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    p_sum  <= {p_sum[LAT-2:0], fa_a ^ fa_b ^ fa_cin};
    p_cout <= {p_cout[LAT-2:0], (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin)};
  end

  assign rel_c    = cyc - t0 + 1;
  // Non-sample WAIT cycles of each bit period (rel mod P = 2 or 3).
  assign spur_now = spur_en && rel_c >= 2 && rel_c <= FirstOv - 1 &&
                    (rel_c % P == 2 || rel_c % P == 3);
  assign fa_sum   = p_sum[LAT-1] | spur_now;
  assign fa_cout  = p_cout[LAT-1] | spur_now;

  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             op_cin = 1'b0;
  logic             op_act = 1'b0;
  logic             ov_prev = 1'b0;
  logic [WIDTH:0]   sb[$];
  int               xfer_cnt = 0;
  int               pop_cnt = 0;
  int               hs_c = 0;

  function automatic logic [2:0] exp_fa(input int rel);
    logic c;
    int   i;
    if (!op_act || rel < 1 || rel > (WIDTH - 1) * P + 1 || (rel - 1) % P != 0) return 3'b000;
    i = (rel - 1) / P;
    c = op_cin;
    for (int k = 0; k < i; k++) c = (op_a[k] & op_b[k]) | (op_a[k] & c) | (op_b[k] & c);
    return {op_a[i], op_b[i], c};
  endfunction

  // Inputs change at posedge+1, so the negedge view equals what the next edge sees.
  always @(negedge clk) begin
    logic [WIDTH:0] exp;
    int rel;
    rel = cyc - t0 + 1;
    check_eq("fa_pulses", {29'd0, fa_a, fa_b, fa_cin}, {29'd0, exp_fa(rel)});
    if (op_act && out_valid && !ov_prev) check_eq("first_valid_cycle", rel, FirstOv);
    ov_prev = out_valid;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out", 32'd1, 32'd0);
      end else begin
        exp = sb.pop_front();
        check_eq("result", {23'd0, out_cout, out_sum}, {23'd0, exp});
      end
      pop_cnt++;
      hs_c = cyc;
    end
    if (rst) begin
      sb.delete();
      op_act  = 1'b0;
      ov_prev = 1'b0;
    end else if (in_valid && in_ready) begin
      sb.push_back({1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin});
      op_a   = in_a;
      op_b   = in_b;
      op_cin = in_cin;
      op_act = 1'b1;
      t0     = cyc + 1;
      xfer_cnt++;
    end
  end

  task automatic do_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    int n;
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    in_valid = 1'b1;
    n        = xfer_cnt;
    for (int k = 0; k < 200 && xfer_cnt == n; k++) begin
      @(posedge clk);
      #1;
    end
    if (xfer_cnt == n) check_eq("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int n;
    n = pop_cnt;
    for (int k = 0; k < 200 && pop_cnt == n; k++) begin
      @(posedge clk);
      #1;
    end
    if (pop_cnt == n) check_eq("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    do_req(a, b, c);
    wait_result();
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_out_sum", out_sum, 0);
    check_eq("rst_out_cout", out_cout, 0);
    check_eq("rst_fa", {fa_a, fa_b, fa_cin}, 0);
    @(posedge clk);
    #1;

    run(8'hFF, 8'h01, 1'b0);
    run(8'hA5, 8'h5A, 1'b1);
    run(8'h00, 8'h00, 1'b0);

    // Backpressure with a pending request waiting behind the result.
    out_ready = 1'b0;
    do_req(8'h3C, 8'h0F, 1'b0);
    for (int k = 0; k < 200 && !out_valid; k++) begin
      @(posedge clk);
      #1;
    end
    in_a     = 8'h11;
    in_b     = 8'h22;
    in_cin   = 1'b1;
    in_valid = 1'b1;
    repeat (10) begin
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_result", {out_cout, out_sum}, 9'h04B);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    n = xfer_cnt;
    for (int k = 0; k < 20 && xfer_cnt == n; k++) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_eq("bp_accepted", xfer_cnt - n, 1);
    check_eq("accept_after_hs", t0 - hs_c, 2);
    wait_result();

    // Reset in cycle 15 of an operation.
    do_req(8'h77, 8'h99, 1'b0);
    for (int k = 0; k < 50 && rel_c != 15; k++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_fa", {fa_a, fa_b, fa_cin}, 0);
    check_eq("mid_rst_out_valid", out_valid, 0);
    repeat (40) @(posedge clk);
    #1;
    run(8'h12, 8'h34, 1'b0);

    spur_en = 1'b1;
    run(8'h01, 8'h01, 1'b0);
    spur_en = 1'b0;
    check_eq("sb_empty", sb.size(), 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Bit-serial controller that computes a WIDTH-bit add through a single external clocked 1-bit full adder. The full adder has a fixed FA_LATENCY-cycle pipeline.
- Accepts a pair of operands, feeds them LSB-first, and routes each returned carry back as the next bit's carry-in. It collects the sum bits and presents the WIDTH-bit result plus carry-out.
- Sits between a word-level requester and the gate-level adder cell, so wide adds need only one adder instance.

Parameters:
- WIDTH, 8, operand and sum width in bits (>=2).
- FA_LATENCY, 3, clock cycles from driving fa_a/fa_b/fa_cin to valid fa_sum/fa_cout (>=1).

Ports:
- clk  input  1  single clock for the block and the adder cell.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  high only in IDLE; a transfer occurs when in_valid and in_ready are both high.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in for bit 0.
- out_valid  output  1  result available.
- out_ready  input  1  result consumed when out_valid and out_ready are both high.
- out_sum  output  WIDTH  sum.
- out_cout  output  1  final carry-out.
- busy  output  1  high in ISSUE, WAIT or DONE.
- fa_a  output  1  A bit to the adder.
- fa_b  output  1  B bit to the adder.
- fa_cin  output  1  carry bit to the adder.
- fa_sum  input  1  sum from the adder.
- fa_cout  input  1  carry from the adder.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - in_ready=1.
  - out_valid=0, out_sum=0, out_cout=0, busy=0.
  - fa_a=fa_b=fa_cin=0.
  - Bit counter and wait counter are 0.
  - Reset asserted mid-operation abandons the operation. No out_valid pulse follows, and fa_* are 0 on the next cycle.
- fa_a, fa_b and fa_cin are registered outputs. They are nonzero only during an issue cycle and are 0 in every other cycle, because a pulse means logic 1 to the adder cell.
- Bit period P = FA_LATENCY+1.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On a transfer, latch in_a, in_b and in_cin into shift/carry registers, clear the bit index i, and go to ISSUE.
    - in_valid in any other state is ignored.
  - ISSUE (1 cycle):
    - Drive fa_a=A[i], fa_b=B[i], fa_cin=carry, where carry=in_cin when i=0.
    - Load the wait counter with FA_LATENCY and go to WAIT.
  - WAIT:
    - Hold fa_*=0 and decrement the wait counter.
    - In the cycle where the counter reads 1, sample fa_sum into sum bit i and fa_cout into the carry register.
    - If i=WIDTH-1, go to DONE. Otherwise increment i and go to ISSUE.
    - fa_sum and fa_cout are ignored in every cycle except the sample cycle.
  - DONE:
    - out_valid=1; out_sum and out_cout are stable.
    - On out_ready, go to IDLE on that edge.
    - in_ready stays 0 until IDLE is reached, so a back-to-back request is accepted one cycle after the result handshake at the earliest.
- Timing, with the transfer edge ending cycle 0:
  - Bit i is issued in cycle 1+i*P.
  - Bit i is sampled at the end of cycle 1+i*P+FA_LATENCY.
  - out_valid first rises in cycle WIDTH*P+1, which is cycle 33 for the defaults.
- Width rules:
  - out_sum bit i comes from the i-th sample.
  - out_cout is the fa_cout of bit WIDTH-1.
  - There is no overflow flag.
  - i is a ceil(log2(WIDTH))-bit counter that never wraps within an operation.
- out_valid is held with out_sum and out_cout stable for any duration of out_ready=0.
- Input operands are sampled only on the transfer edge. Later changes to in_a or in_b do not affect the operation in flight.

Test Plan:
- The bench model of the adder cell registers sum and carry with a latency of 3 cycles.
- in_a=8'hFF, in_b=8'h01, in_cin=0:
  - out_sum=8'h00 and out_cout=1, with out_valid first high in cycle 33.
  - fa_a is high in cycles 1,5,...,29; fa_b is high only in cycle 1; fa_cin is high in cycles 5..29 every 4 cycles.
- in_a=8'hA5, in_b=8'h5A, in_cin=1 -> out_sum=8'h00, out_cout=1. Then 8'h00+8'h00 with cin=0 -> out_sum=0, out_cout=0, and fa_a, fa_b and fa_cin stay 0 for the whole operation.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid rises.
  - out_valid and the result are held, in_ready=0 throughout, and a pending in_valid with new operands is not accepted.
  - That request is accepted one cycle after the result handshake.
- Reset asserted in cycle 15 of an operation:
  - Next cycle shows in_ready=1, busy=0, fa_*=0, out_valid=0.
  - A new request 8'h12+8'h34 then returns 8'h46, cout=0.
- Spurious pulses: the bench forces fa_sum=1 and fa_cout=1 during non-sample WAIT cycles of 8'h01+8'h01. The result is still 8'h02, cout=0.
